// File: rtl/counter_seq_ctrl.sv
// Command sequencer for the 8-bit up/down counter: turns LOAD/COUNT commands
// into registered counter controls, tracks run length, overflow and illegal ops.
module counter_seq_ctrl #(
  parameter int DATA_W      = 8,
  parameter int LEN_W       = 8,
  parameter int STEP_W      = 1,
  parameter bit STOP_ON_OVF = 1'b1,
  localparam int ARG_W      = (DATA_W > LEN_W) ? DATA_W : LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [ARG_W-1:0]  cmd_arg_i,
  input  logic [STEP_W-1:0] cmd_step_i,
  input  logic              abort_i,
  input  logic              cnt_ovf_i,
  output logic              cnt_load_o,
  output logic [DATA_W-1:0] cnt_data_o,
  output logic              cnt_enable_o,
  output logic              cnt_up_down_o,
  output logic [STEP_W-1:0] cnt_step_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              ovf_flag_o,
  output logic              err_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic                up_q, up_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                ovf_q, ovf_d;
  logic                err_q, err_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      up_q    <= 1'b0;
      step_q  <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      up_q    <= up_d;
      step_q  <= step_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    up_d    = up_q;
    step_d  = step_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          ovf_d = 1'b0;
          err_d = 1'b0;
          case (cmd_op_i)
            OP_LOAD: begin
              data_d  = cmd_arg_i[DATA_W-1:0];
              up_d    = 1'b0;
              step_d  = '0;
              state_d = ST_LOAD;
            end
            OP_UP, OP_DOWN: begin
              rem_d   = cmd_arg_i[LEN_W-1:0];
              up_d    = (cmd_op_i == OP_UP);
              step_d  = cmd_step_i;
              state_d = (cmd_arg_i[LEN_W-1:0] == '0) ? ST_DONE : ST_RUN;
            end
            default: begin
              err_d   = 1'b1;
              up_d    = 1'b0;
              step_d  = '0;
              state_d = ST_DONE;
            end
          endcase
        end
      end
      ST_LOAD: state_d = ST_DONE;
      ST_RUN: begin
        rem_d = rem_q - LEN_W'(1);
        if (cnt_ovf_i) ovf_d = 1'b1;
        // Abort and overflow may coincide; the flag above still takes effect.
        if ((rem_q == LEN_W'(1)) || abort_i || (STOP_ON_OVF && cnt_ovf_i))
          state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready_o   = (state_q == ST_IDLE);
  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = (state_q == ST_DONE);
  assign cnt_load_o    = (state_q == ST_LOAD);
  assign cnt_enable_o  = (state_q == ST_RUN);
  assign cnt_data_o    = data_q;
  // Direction/step persist through DONE and drop back to zero in IDLE.
  assign cnt_up_down_o = (state_q != ST_IDLE) & up_q;
  assign cnt_step_o    = (state_q != ST_IDLE) ? step_q : '0;
  assign ovf_flag_o    = ovf_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl: two instances (stop-on-overflow on/off) each
// driving a behavioural 8-bit counter; per-command results go through a scoreboard.
module tb_counter_seq_ctrl;

  typedef struct {
    int lat;
    int en;
    int ld;
    int ovf;
    int err;
    int cnt;
    int ctl_bad;
  } res_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_arg = 8'h00;
  logic [0:0] cmd_step = 1'b0;
  logic       abort = 1'b0;

  logic       ready_a, ld_a, en_a, ud_a, busy_a, done_a, flag_a, err_a;
  logic [7:0] data_a;
  logic [0:0] stp_a;
  logic       ready_b, ld_b, en_b, ud_b, busy_b, done_b, flag_b, err_b;
  logic [7:0] data_b;
  logic [0:0] stp_b;

  logic [7:0] cnt_a = 8'h00;
  logic [7:0] cnt_b = 8'h00;
  logic [7:0] inc_a, inc_b;
  logic       ovf_a, ovf_b;

  int checks = 0;
  int errors = 0;
  res_t q_a[$];
  res_t q_b[$];

  always #5 clk = ~clk;

  counter_seq_ctrl #(.DATA_W(8), .LEN_W(8), .STEP_W(1), .STOP_ON_OVF(1'b1)) dut_a (
    .clk(clk), .reset(reset), .cmd_valid_i(cmd_valid), .cmd_ready_o(ready_a),
    .cmd_op_i(cmd_op), .cmd_arg_i(cmd_arg), .cmd_step_i(cmd_step), .abort_i(abort),
    .cnt_ovf_i(ovf_a), .cnt_load_o(ld_a), .cnt_data_o(data_a), .cnt_enable_o(en_a),
    .cnt_up_down_o(ud_a), .cnt_step_o(stp_a), .busy_o(busy_a), .done_o(done_a),
    .ovf_flag_o(flag_a), .err_o(err_a)
  );

  counter_seq_ctrl #(.DATA_W(8), .LEN_W(8), .STEP_W(1), .STOP_ON_OVF(1'b0)) dut_b (
    .clk(clk), .reset(reset), .cmd_valid_i(cmd_valid), .cmd_ready_o(ready_b),
    .cmd_op_i(cmd_op), .cmd_arg_i(cmd_arg), .cmd_step_i(cmd_step), .abort_i(abort),
    .cnt_ovf_i(ovf_b), .cnt_load_o(ld_b), .cnt_data_o(data_b), .cnt_enable_o(en_b),
    .cnt_up_down_o(ud_b), .cnt_step_o(stp_b), .busy_o(busy_b), .done_o(done_b),
    .ovf_flag_o(flag_b), .err_o(err_b)
  );

  // Behavioural counter: step code 0 -> +/-1, 1 -> +/-2; ovf flags a wrap this cycle.
  assign inc_a = stp_a[0] ? 8'd2 : 8'd1;
  assign inc_b = stp_b[0] ? 8'd2 : 8'd1;
  assign ovf_a = en_a && (ud_a ? ((9'(cnt_a) + 9'(inc_a)) > 9'd255) : (cnt_a < inc_a));
  assign ovf_b = en_b && (ud_b ? ((9'(cnt_b) + 9'(inc_b)) > 9'd255) : (cnt_b < inc_b));

  always @(posedge clk) begin
    if (ld_a) cnt_a <= data_a;
    else if (en_a) cnt_a <= ud_a ? cnt_a + inc_a : cnt_a - inc_a;
    if (ld_b) cnt_b <= data_b;
    else if (en_b) cnt_b <= ud_b ? cnt_b + inc_b : cnt_b - inc_b;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic res_t mk(input int lat, input int en, input int ld,
                              input int ovf, input int err, input int cnt);
    res_t r;
    r.lat = lat; r.en = en; r.ld = ld; r.ovf = ovf; r.err = err; r.cnt = cnt;
    r.ctl_bad = 0;
    return r;
  endfunction

  task automatic observe(input int c, input logic en, input logic ld, input logic ud,
                         input logic [0:0] stp, input logic [7:0] data, input logic ready,
                         input logic dn, input logic flag, input logic err,
                         input logic [7:0] cnt, input logic exp_ud, input logic exp_stp,
                         input logic [7:0] exp_data, inout res_t r, inout bit fin);
    if (!fin) begin
      if (en) begin
        r.en++;
        if (ud !== exp_ud || stp[0] !== exp_stp) r.ctl_bad++;
      end
      if (ld) begin
        r.ld++;
        if (data !== exp_data) r.ctl_bad++;
      end
      if (ready) r.ctl_bad++;
      if (dn) begin
        r.lat = c; r.ovf = int'(flag); r.err = int'(err); r.cnt = int'(cnt);
        fin = 1'b1;
      end
    end
  endtask

  task automatic compare(input string tag, input res_t o, input res_t e);
    chk({tag, "/lat"},  o.lat, e.lat);
    chk({tag, "/en"},   o.en, e.en);
    chk({tag, "/ld"},   o.ld, e.ld);
    chk({tag, "/ovf"},  o.ovf, e.ovf);
    chk({tag, "/err"},  o.err, e.err);
    chk({tag, "/cnt"},  o.cnt, e.cnt);
    chk({tag, "/ctl"},  o.ctl_bad, e.ctl_bad);
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [7:0] arg,
                         input logic stp, input int abort_at, input res_t e_a, input res_t e_b);
    res_t o_a, o_b, ea, eb;
    bit f_a, f_b;
    int c;
    logic exp_ud;
    exp_ud = (op == 2'b01);
    q_a.push_back(e_a);
    q_b.push_back(e_b);
    o_a = mk(-1, 0, 0, 0, 0, 0);
    o_b = mk(-1, 0, 0, 0, 0, 0);
    f_a = 1'b0; f_b = 1'b0; c = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg; cmd_step = stp;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    while (!(f_a && f_b) && c < 200) begin
      @(negedge clk);
      c++;
      abort = (c == abort_at);
      observe(c, en_a, ld_a, ud_a, stp_a, data_a, ready_a, done_a, flag_a, err_a, cnt_a,
              exp_ud, stp, arg, o_a, f_a);
      observe(c, en_b, ld_b, ud_b, stp_b, data_b, ready_b, done_b, flag_b, err_b, cnt_b,
              exp_ud, stp, arg, o_b, f_b);
    end
    abort = 1'b0;
    chk({tag, "/finished"}, int'(f_a && f_b), 1);
    ea = q_a.pop_front();
    eb = q_b.pop_front();
    compare({tag, "/stop1"}, o_a, ea);
    compare({tag, "/stop0"}, o_b, eb);
    $display("cmd %s op=%0d arg=%0h lat=%0d/%0d en=%0d/%0d cnt=%0h/%0h ovf=%0d/%0d err=%0d",
             tag, op, arg, o_a.lat, o_b.lat, o_a.en, o_b.en, o_a.cnt, o_b.cnt,
             o_a.ovf, o_b.ovf, o_a.err);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst/ready", ready_a, 1);
    chk("rst/busy", busy_a, 0);
    chk("rst/done", done_a, 0);
    chk("rst/en", en_a, 0);
    chk("rst/ld", ld_a, 0);
    chk("rst/ud", ud_a, 0);
    chk("rst/data", data_a, 0);
    chk("rst/flags", {flag_a, err_a}, 0);
    reset = 1'b0;

    run_cmd("load_a5", 2'b00, 8'hA5, 1'b0, -1, mk(2, 0, 1, 0, 0, 8'hA5), mk(2, 0, 1, 0, 0, 8'hA5));
    run_cmd("load_10", 2'b00, 8'h10, 1'b0, -1, mk(2, 0, 1, 0, 0, 8'h10), mk(2, 0, 1, 0, 0, 8'h10));
    run_cmd("up5",     2'b01, 8'd5,  1'b0, -1, mk(6, 5, 0, 0, 0, 8'h15), mk(6, 5, 0, 0, 0, 8'h15));
    run_cmd("load_fe", 2'b00, 8'hFE, 1'b0, -1, mk(2, 0, 1, 0, 0, 8'hFE), mk(2, 0, 1, 0, 0, 8'hFE));
    run_cmd("up6_ovf", 2'b01, 8'd6,  1'b0, -1, mk(3, 2, 0, 1, 0, 8'h00), mk(7, 6, 0, 1, 0, 8'h04));
    run_cmd("load_80", 2'b00, 8'h80, 1'b0, -1, mk(2, 0, 1, 0, 0, 8'h80), mk(2, 0, 1, 0, 0, 8'h80));
    run_cmd("dn20_abort", 2'b10, 8'd20, 1'b0, 3, mk(4, 3, 0, 0, 0, 8'h7D), mk(4, 3, 0, 0, 0, 8'h7D));
    run_cmd("up0",     2'b01, 8'd0,  1'b0, -1, mk(1, 0, 0, 0, 0, 8'h7D), mk(1, 0, 0, 0, 0, 8'h7D));
    run_cmd("dn4_step2", 2'b10, 8'd4, 1'b1, -1, mk(5, 4, 0, 0, 0, 8'h75), mk(5, 4, 0, 0, 0, 8'h75));
    run_cmd("illegal", 2'b11, 8'h5A, 1'b1, -1, mk(1, 0, 0, 0, 1, 8'h75), mk(1, 0, 0, 0, 1, 8'h75));
    @(negedge clk);
    chk("illegal/err_sticky", err_a, 1);
    chk("illegal/ud_idle", {ud_a, stp_a}, 0);
    run_cmd("load_33", 2'b00, 8'h33, 1'b0, -1, mk(2, 0, 1, 0, 0, 8'h33), mk(2, 0, 1, 0, 0, 8'h33));

    // Valid held across DONE: the follow-up COUNT_UP is taken on the first IDLE edge.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_arg = 8'h44; cmd_step = 1'b0;
    @(posedge clk);
    #1 cmd_op = 2'b01; cmd_arg = 8'd2;
    @(negedge clk);
    chk("b2b/load_ready", ready_a, 0);
    chk("b2b/load", ld_a, 1);
    @(negedge clk);
    chk("b2b/done_ready", ready_a, 0);
    chk("b2b/done", done_a, 1);
    @(negedge clk);
    chk("b2b/idle_ready", ready_a, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("b2b/run1", {en_a, ud_a, ready_a}, 3'b110);
    @(negedge clk);
    chk("b2b/run2", en_a, 1);
    @(negedge clk);
    chk("b2b/done2", {done_a, en_a}, 2'b10);
    chk("b2b/cnt", cnt_a, 8'h46);
    $display("cmd b2b load 44 then up 2 cnt=%0h", cnt_a);

    // Asynchronous reset landing mid-RUN.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_arg = 8'd10; cmd_step = 1'b0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("rstrun/pre_en", en_a, 1);
    reset = 1'b1;
    #1;
    chk("rstrun/en", {en_a, en_b}, 0);
    chk("rstrun/ready", {ready_a, ready_b}, 2'b11);
    chk("rstrun/busy", {busy_a, busy_b}, 0);
    chk("rstrun/done", {done_a, done_b}, 0);
    chk("rstrun/ud", {ud_a, ud_b}, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstrun/no_done", {done_a, done_b, busy_a, busy_b}, 0);
    end
    $display("cmd reset_mid_run en=%0b ready=%0b", en_a, ready_a);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
- Command-driven sequencer for the 8-bit up/down counter datapath.
- Accepts one command at a time over a valid/ready interface and translates it into the counter's control signals: load, data, enable, up_down and step.
- Monitors the counter's overflow output, reports completion, and records overflow and illegal-command status.
- Sits between the stimulus/CPU-side control and the counter instance.

Parameters:
- DATA_W, 8, width of counter load data (matches counter cnt_o width)
- LEN_W, 8, width of the run-length argument (max 2^LEN_W-1 enable cycles)
- STEP_W, 1, width of the step code driven to the counter
- STOP_ON_OVF, 1, 1: a RUN terminates after the first overflow cycle; 0: the run completes its full length

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  controller can accept a command (high only in IDLE)
- cmd_op_i  in  2  opcode: 00 LOAD, 01 COUNT_UP, 10 COUNT_DOWN, 11 illegal
- cmd_arg_i  in  max(DATA_W,LEN_W)  LOAD: value to load; COUNT_*: number of enable cycles N
- cmd_step_i  in  STEP_W  step code for COUNT_*
- abort_i  in  1  terminate the current RUN
- cnt_ovf_i  in  1  counter ovf_o
- cnt_load_o  out  1  to counter load_i
- cnt_data_o  out  DATA_W  to counter data_i
- cnt_enable_o  out  1  to counter enable_i
- cnt_up_down_o  out  1  to counter up_down_i (1 = up)
- cnt_step_o  out  STEP_W  to counter cnt_step_i
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse at command completion
- ovf_flag_o  out  1  sticky: overflow seen during the last command
- err_o  out  1  sticky: last command was illegal

Behaviour:
- Reset (asynchronous, immediate, valid mid-command):
  - State = IDLE.
  - All outputs 0 except cmd_ready_o = 1.
  - Internal remaining-count and step registers cleared.
- States: IDLE, LOAD, RUN, DONE. All control outputs are registered or decoded from state; there is no combinational path from cmd_* to cnt_*.
- Acceptance: a command is accepted on a rising edge where cmd_valid_i && cmd_ready_o. On acceptance:
  - ovf_flag_o and err_o clear.
  - op, arg and step are captured.
  - cmd_ready_o drops in the next cycle.
- LOAD:
  - Next cycle is the LOAD state: cnt_load_o = 1 and cnt_data_o = arg[DATA_W-1:0] for exactly one cycle.
  - Then DONE.
  - Latency from the accept edge to done_o high is 2 cycles.
- COUNT_UP / COUNT_DOWN with N = 0: go directly to DONE. No enable is issued and done_o is high 1 cycle after the accept edge.
- COUNT_UP / COUNT_DOWN with N > 0:
  - RUN state for exactly N cycles with cnt_enable_o = 1, cnt_up_down_o = (op == COUNT_UP), cnt_step_o = captured step.
  - The remaining count decrements each RUN cycle; leave RUN on the edge where remaining == 1.
  - cnt_up_down_o and cnt_step_o hold their values during DONE and return to 0 in IDLE.
  - cnt_data_o holds its last loaded value.
- Overflow:
  - cnt_ovf_i is sampled only in cycles where cnt_enable_o = 1 (RUN).
  - When sampled high, ovf_flag_o = 1 from the next cycle.
  - With STOP_ON_OVF = 1, RUN also exits to DONE on that edge, so enable is deasserted next cycle.
  - With STOP_ON_OVF = 0, the run continues for its full N.
  - Overflow on the final RUN cycle: same DONE timing, flag set.
- abort_i:
  - Honoured only in RUN; leave to DONE on the edge where it is sampled high.
  - If abort and overflow occur in the same cycle, both the exit and the flag take effect.
  - Ignored in IDLE, LOAD and DONE.
- Illegal op (11): go to DONE next cycle, err_o = 1, no counter control asserted.
- DONE: done_o = 1 and cmd_ready_o = 0 for one cycle, then IDLE.
- A cmd_valid_i held high across DONE is accepted on the first IDLE edge. Minimum command spacing is therefore 3 cycles for LOAD and N+2 cycles for COUNT.

Test Plan:
- Reset while in RUN (N = 10, cycle 4): cnt_enable_o = 0 immediately; cmd_ready_o = 1; busy_o = 0; no done_o pulse.
- LOAD arg = 0xA5: cnt_load_o high exactly 1 cycle with cnt_data_o = 0xA5; done_o 2 cycles after the accept edge; counter then reads 0xA5.
- LOAD 0x10, then COUNT_UP N = 5, step = 0: cnt_enable_o high exactly 5 cycles with up_down = 1; counter reaches 0x15; ovf_flag_o = 0.
- LOAD 0xFE, then COUNT_UP N = 6, STOP_ON_OVF = 1: overflow at the wrap; enable drops the cycle after overflow is sampled (fewer than 6 enable cycles); ovf_flag_o = 1; done_o pulses. With STOP_ON_OVF = 0: 6 enable cycles and flag = 1.
- COUNT_DOWN N = 20, abort_i pulsed on RUN cycle 3: exactly 3 enable cycles; done_o next cycle. Also COUNT_UP N = 0: zero enable cycles and done_o 1 cycle after accept.
- op = 11: err_o = 1, no cnt_* activity, done_o pulses. A following valid LOAD clears err_o on its accept edge. Back-to-back valid commands see cmd_ready_o low during LOAD/RUN/DONE.
